// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: two-phase (address then data) multiplexed RTC bus transaction sequencer
module rtc_bus_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 7,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_write,
  input  logic       req_read,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  input  logic [7:0] bus_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe
);
  typedef enum logic [3:0] {IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE} state_t;
  state_t state, nxt;
  logic [3:0] cnt, dur;
  logic [7:0] addr_q, wdata_q, addr_n, wdata_n;
  logic last, acc, wr_q, dir, in_a, in_d;
  // outputs are decoded from the next state so they register in step with it
  always_comb begin
    dur = (state == A_SETUP || state == D_SETUP) ? 4'(T_SETUP) :
          (state == A_STROBE || state == D_STROBE) ? 4'(T_PULSE) :
          (state == A_HOLD || state == D_HOLD) ? 4'(T_HOLD) : 4'(T_GAP);
    last = cnt == dur - 4'd1;
    acc = state == IDLE && (req_write || req_read);
    nxt = state;
    if (state == IDLE) nxt = acc ? A_SETUP : IDLE;
    else if (state == DONE) nxt = IDLE;
    else if (last) nxt = state_t'(state + 4'd1);
    dir = state == IDLE ? req_write : wr_q;
    addr_n = acc ? address : addr_q;
    wdata_n = acc ? wdata : wdata_q;
    in_a = nxt inside {A_SETUP, A_STROBE, A_HOLD};
    in_d = nxt inside {D_SETUP, D_STROBE, D_HOLD};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
      cs_n <= 1'b1;
      rd_n <= 1'b1;
      wr_n <= 1'b1;
      ad <= 1'b0;
      bus_out <= '0;
      bus_oe <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt == state && state != IDLE) ? cnt + 4'd1 : 4'd0;
      wr_q <= dir;
      addr_q <= addr_n;
      wdata_q <= wdata_n;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      cs_n <= !(in_a || in_d);
      ad <= in_d;
      wr_n <= !(nxt == A_STROBE || (nxt == D_STROBE && dir));
      rd_n <= !(nxt == D_STROBE && !dir);
      bus_oe <= in_a || (in_d && dir);
      bus_out <= in_a ? addr_n : (in_d && dir) ? wdata_n : 8'h00;
      if (state == D_STROBE && last && !wr_q) rdata <= bus_in;
    end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed checks of default and minimum-timing sequencers
module tb_rtc_bus_sequencer;
  logic clk = 0, rst_n = 0, req_write = 0, req_read = 0, sel = 0;
  logic [7:0] address = 0, wdata = 0, bus_in = 0;
  logic busy0, done0, cs_n0, rd_n0, wr_n0, ad0, oe0, busy1, done1, cs_n1, rd_n1, wr_n1, ad1, oe1;
  logic [7:0] rdata0, bo0, rdata1, bo1;
  int checks = 0, errors = 0;
  wire [6:0] v0 = {cs_n0, rd_n0, wr_n0, ad0, oe0, busy0, done0};
  wire [6:0] v1 = {cs_n1, rd_n1, wr_n1, ad1, oe1, busy1, done1};
  wire [6:0] vo = sel ? v1 : v0;
  wire [7:0] bo = sel ? bo1 : bo0;
  wire [7:0] rdo = sel ? rdata1 : rdata0;
  rtc_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_write(req_write), .req_read(req_read), .address(address),
    .wdata(wdata), .bus_in(bus_in), .busy(busy0), .done(done0), .rdata(rdata0), .cs_n(cs_n0),
    .rd_n(rd_n0), .wr_n(wr_n0), .ad(ad0), .bus_out(bo0), .bus_oe(oe0));
  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_min (
    .clk(clk), .rst_n(rst_n), .req_write(req_write), .req_read(req_read), .address(address),
    .wdata(wdata), .bus_in(bus_in), .busy(busy1), .done(done1), .rdata(rdata1), .cs_n(cs_n1),
    .rd_n(rd_n1), .wr_n(wr_n1), .ad(ad1), .bus_out(bo1), .bus_oe(oe1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string name, input logic w, input logic [7:0] a, d, bi, prev, input int inj, stop);
    int ts, tp, th, tg, ast, aho, gp, dsu, dst, dho, dn, n;
    logic ia, id, ds;
    ts = sel ? 1 : 2; tp = sel ? 1 : 7; th = sel ? 1 : 2; tg = sel ? 1 : 4;
    ast = ts; aho = ts + tp; gp = aho + th; dsu = gp + tg; dst = dsu + ts; dho = dst + tp; dn = dho + th;
    n = stop >= 0 ? stop : dn + 2;
    @(posedge clk); #1;
    req_write = 0;
    req_read = 0;
    for (int c = 0; c < n; c++) begin
      ia = c < gp;
      id = c >= dsu && c < dn;
      ds = c >= dst && c < dho;
      bus_in = bi;
      check($sformatf("%s ctl c%0d", name, c), 32'(vo),
            32'({!(ia || id), !(ds && !w), !((c >= ast && c < aho) || (ds && w)), id, ia || (id && w), c <= dn, c == dn}));
      check($sformatf("%s bus c%0d", name, c), 32'(bo), 32'(ia ? a : (id && w) ? d : 8'h00));
      check($sformatf("%s rdata c%0d", name, c), 32'(rdo), 32'((!w && c >= dho) ? bi : prev));
      req_read = c == inj;
      @(posedge clk); #1;
    end
    req_read = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", 32'(v0), 32'(7'b1110000));
    check("reset bus", 32'(bo0), 32'(0));
    check("reset rdata", 32'(rdata0), 32'(0));
    rst_n = 1;
    address = 8'h21; wdata = 8'h45; req_write = 1;
    run("wr", 1, 8'h21, 8'h45, 8'h00, 8'h00, -1, -1);
    address = 8'h22; req_read = 1;
    run("rd", 0, 8'h22, 8'h00, 8'h37, 8'h00, -1, -1);
    address = 8'h30; wdata = 8'h5a; req_write = 1; req_read = 1;
    run("both", 1, 8'h30, 8'h5a, 8'h99, 8'h37, -1, -1);
    address = 8'h40; wdata = 8'h11; req_write = 1;
    run("wr_ign", 1, 8'h40, 8'h11, 8'h66, 8'h37, 10, -1);
    address = 8'h55; req_read = 1;
    run("rd_rst", 0, 8'h55, 8'h00, 8'h7e, 8'h37, -1, 20);
    rst_n = 0;
    #1;
    check("abort ctl", 32'(v0), 32'(7'b1110000));
    check("abort bus", 32'(bo0), 32'(0));
    check("abort rdata", 32'(rdata0), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    check("abort hold ctl", 32'(v0), 32'(7'b1110000));
    rst_n = 1;
    address = 8'h12; wdata = 8'h34; req_write = 1;
    run("wr_post", 1, 8'h12, 8'h34, 8'h00, 8'h00, -1, -1);
    sel = 1;
    address = 8'h0f; req_read = 1;
    run("min_rd", 0, 8'h0f, 8'h00, 8'hc3, 8'h00, -1, -1);
    address = 8'h81; wdata = 8'h18; req_write = 1;
    run("min_wr", 1, 8'h81, 8'h18, 8'h00, 8'hc3, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
